// File: rtl/vga_scandoubler.sv
// Ping-pong line buffer that doubles 15 kHz PAL lines to 31 kHz VGA, with registered bypass.
// Define SCANLINES_EN to darken the second output pass of each stored line.
module vga_scandoubler #(
   parameter int LINE_LEN_RST = 448,
   parameter int HS_START     = 0,
   parameter int HS_WIDTH     = 54,
   parameter int MIN_LINE     = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clken_in,
   input  logic       clken_out,
   input  logic       enable,
   input  logic       scanlines,
   input  logic [2:0] ri,
   input  logic [2:0] gi,
   input  logic [2:0] bi,
   input  logic       hsync_in,
   input  logic       vsync_in,
   output logic [2:0] ro,
   output logic [2:0] go,
   output logic [2:0] bo,
   output logic       hsync,
   output logic       vsync
);
   localparam logic [8:0]  LEN_RST = 9'(LINE_LEN_RST);
   localparam logic [8:0]  MIN_LEN = 9'(MIN_LINE);
   localparam logic [10:0] HS_LO   = 11'(HS_START);
   localparam logic [9:0]  HS_W    = 10'(HS_WIDTH);

   logic [8:0]  mem [0:1023];
   logic [8:0]  rdata;
   logic [8:0]  wptr;
   logic [8:0]  rptr;
   logic [8:0]  line_len;
   logic        wbank;
   logic        pass;
   logic        hs_d;
   logic        hs_fall;
   logic        swap;
   logic [10:0] hs_off;
   logic        hs_win;
   logic        hs_p1;
   logic        vs_p1;
   logic [8:0]  col_dbl;

   // Short lines are sync glitches: the edge is dropped and the write pointer keeps running.
   assign swap = hs_fall && (wptr >= MIN_LEN);

   // An rptr below HS_START borrows into bit 10, keeping the window test free of wrap-around.
   assign hs_off = {2'b00, rptr} - HS_LO;
   assign hs_win = !hs_off[10] && (hs_off[9:0] < HS_W);

   always_ff @(posedge clk) begin
      if (clken_in) mem[{wbank, wptr}] <= {ri, gi, bi};
      rdata <= mem[{~wbank, rptr}];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hs_d     <= 1'b1;
         hs_fall  <= 1'b0;
         wbank    <= 1'b0;
         wptr     <= '0;
         rptr     <= '0;
         pass     <= 1'b0;
         line_len <= LEN_RST;
      end else begin
         hs_d    <= hsync_in;
         hs_fall <= hs_d & ~hsync_in;
         if (swap) begin
            line_len <= wptr;
            wbank    <= ~wbank;
            wptr     <= '0;
            rptr     <= '0;
            pass     <= 1'b0;
         end else begin
            if (clken_in && wptr != 9'h1FF) wptr <= wptr + 9'd1;
            if (clken_out) begin
               if (rptr == line_len - 9'd1) begin
                  rptr <= '0;
                  pass <= ~pass;
               end else begin
                  rptr <= rptr + 9'd1;
               end
            end
         end
      end
   end

`ifdef SCANLINES_EN
   logic pass_d1;

   // pass is delayed one clk so it lines up with the RAM read data.
   always_ff @(posedge clk) begin
      if (rst) pass_d1 <= 1'b0;
      else     pass_d1 <= pass;
   end

   always_comb begin
      col_dbl = rdata;
      if (scanlines && pass_d1)
         col_dbl = {1'b0, rdata[8:7], 1'b0, rdata[5:4], 1'b0, rdata[2:1]};
   end
`else
   logic unused_bits;
   assign unused_bits = ^{scanlines, pass};
   assign col_dbl     = rdata;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         ro    <= '0;
         go    <= '0;
         bo    <= '0;
         hsync <= 1'b1;
         vsync <= 1'b1;
         hs_p1 <= 1'b1;
         vs_p1 <= 1'b1;
      end else begin
         hs_p1 <= ~hs_win;
         vs_p1 <= vsync_in;
         if (enable) begin
            {ro, go, bo} <= col_dbl;
            hsync        <= hs_p1;
            vsync        <= vs_p1;
         end else begin
            {ro, go, bo} <= {ri, gi, bi};
            hsync        <= hsync_in;
            vsync        <= vsync_in;
         end
      end
   end
endmodule

// File: tb/tb_vga_scandoubler.sv
// Directed bench for vga_scandoubler: ramp doubling, glitch rejection, long lines, bypass, scanlines, vsync.
module tb_vga_scandoubler;
   logic       clk = 1'b0;
   logic       rst, clken_in, clken_out, enable, scanlines;
   logic [2:0] ri, gi, bi;
   logic       hsync_in, vsync_in;
   logic [2:0] ro, go, bo;
   logic       hsync, vsync;

   always #5 clk = ~clk;

`ifdef SCANLINES_EN
   localparam logic [8:0] SL_EXP = 9'h0DB;
`else
   localparam logic [8:0] SL_EXP = 9'h1FF;
`endif

   int vectors     = 0;
   int miscompares = 0;

   logic [8:0] cur_exp  [0:511];
   logic [8:0] prev_exp [0:511];
   int         cur_len  = 448;
   int         prev_len = 448;
   int         cap_len  = 0;
   logic [8:0] cap_col [0:2399];
   logic [8:0] cap_in  [0:2399];
   logic       cap_hs  [0:2399];
   logic       cap_vs  [0:2399];
   logic       cap_hin [0:2399];
   logic       cap_vin [0:2399];

   vga_scandoubler dut (
      .clk(clk), .rst(rst), .clken_in(clken_in), .clken_out(clken_out),
      .enable(enable), .scanlines(scanlines),
      .ri(ri), .gi(gi), .bi(bi), .hsync_in(hsync_in), .vsync_in(vsync_in),
      .ro(ro), .go(go), .bo(bo), .hsync(hsync), .vsync(vsync)
   );

   function automatic logic [8:0] pix(input int mode, input int j);
      logic [8:0] v;
      v = 9'(j);
      case (mode)
         0:       pix = v;
         1:       pix = 9'h1FF;
         default: pix = v ^ ((j >= 512) ? 9'h0AA : 9'h155);
      endcase
   endfunction

   // One input line of len pixels; the pixel at len-1 carries the hsync fall that ends the line.
   task automatic send_line(input int len, input int mode, input bit lead_low,
                            input bit glitch, input bit en, input bit vs_pulse);
      int j;
      for (int i = 0; i < 512; i++) prev_exp[i] = cur_exp[i];
      prev_len = cur_len;
      for (int c = 0; c < 4 * len; c++) begin
         @(negedge clk);
         j         = c / 4;
         clken_in  = (c % 4 == 0);
         clken_out = (c % 2 == 0);
         enable    = en;
         {ri, gi, bi} = pix(mode, j);
         hsync_in  = !((lead_low && j <= 30) || (j == len - 1) || (glitch && j == 20));
         vsync_in  = !(vs_pulse && c >= 100 && c < 140);
         if (c % 4 == 0) cur_exp[(j > 511) ? 511 : j] = pix(mode, j);
         @(posedge clk);
         #1;
         cap_col[c] = {ro, go, bo};
         cap_hs[c]  = hsync;
         cap_vs[c]  = vsync;
         cap_in[c]  = {ri, gi, bi};
         cap_hin[c] = hsync_in;
         cap_vin[c] = vsync_in;
      end
      cur_len = (len > 511) ? 511 : len;
      cap_len = len;
   endtask

   task automatic test_reset;
      rst = 1'b1; enable = 1'b1; scanlines = 1'b0;
      clken_in = 1'b0; clken_out = 1'b0;
      ri = 3'h7; gi = 3'h7; bi = 3'h7;
      hsync_in = 1'b0; vsync_in = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if ({ro, go, bo} !== 9'h000) begin
         miscompares++;
         $display("FAIL reset_colour: got %h expected 000", {ro, go, bo});
      end
      vectors++;
      if (hsync !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_hsync: got %b expected 1", hsync);
      end
      vectors++;
      if (vsync !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_vsync: got %b expected 1", vsync);
      end
      @(negedge clk);
      rst = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
   endtask

   task automatic test_ramp;
      send_line(448, 0, 1'b0, 1'b0, 1'b1, 1'b0);
      send_line(448, 0, 1'b1, 1'b0, 1'b1, 1'b0);
      for (int r = 0; r < prev_len; r++) begin
         for (int p = 0; p < 2; p++) begin
            int c;
            logic e_hs;
            c    = (p == 0) ? 2 * r - 2 : 2 * prev_len + 2 * r - 2;
            e_hs = (r >= 54) ? 1'b1 : 1'b0;
            if (c >= 0 && c <= 4 * cap_len - 2) begin
               vectors++;
               if (cap_col[c] !== prev_exp[r]) begin
                  miscompares++;
                  $display("FAIL ramp_colour pass%0d px%0d: got %h expected %h", p, r, cap_col[c], prev_exp[r]);
               end
               vectors++;
               if (cap_hs[c] !== e_hs) begin
                  miscompares++;
                  $display("FAIL ramp_hsync pass%0d px%0d: got %b expected %b", p, r, cap_hs[c], e_hs);
               end
            end
         end
      end
   endtask

   task automatic test_glitch;
      send_line(448, 2, 1'b0, 1'b1, 1'b1, 1'b0);
      send_line(448, 0, 1'b1, 1'b0, 1'b1, 1'b0);
      for (int r = 0; r < prev_len; r++) begin
         for (int p = 0; p < 2; p++) begin
            int c;
            c = (p == 0) ? 2 * r - 2 : 2 * prev_len + 2 * r - 2;
            if (c >= 0 && c <= 4 * cap_len - 2) begin
               vectors++;
               if (cap_col[c] !== prev_exp[r]) begin
                  miscompares++;
                  $display("FAIL glitch_colour pass%0d px%0d: got %h expected %h", p, r, cap_col[c], prev_exp[r]);
               end
            end
         end
      end
   endtask

   task automatic test_long_line;
      send_line(600, 0, 1'b1, 1'b0, 1'b1, 1'b0);
      send_line(600, 2, 1'b1, 1'b0, 1'b1, 1'b0);
      for (int r = 0; r < 511; r++) begin
         for (int p = 0; p < 2; p++) begin
            int c;
            logic [8:0] e;
            c = (p == 0) ? 2 * r - 2 : 2 * 511 + 2 * r - 2;
            e = 9'(r);
            if (c >= 0 && c <= 4 * cap_len - 2) begin
               vectors++;
               if (cap_col[c] !== e) begin
                  miscompares++;
                  $display("FAIL long_colour pass%0d px%0d: got %h expected %h", p, r, cap_col[c], e);
               end
            end
         end
      end
      send_line(448, 0, 1'b1, 1'b0, 1'b1, 1'b0);
      for (int r = 0; r < prev_len; r++) begin
         for (int p = 0; p < 2; p++) begin
            int c;
            c = (p == 0) ? 2 * r - 2 : 2 * prev_len + 2 * r - 2;
            if (c >= 0 && c <= 4 * cap_len - 2) begin
               vectors++;
               if (cap_col[c] !== prev_exp[r]) begin
                  miscompares++;
                  $display("FAIL long_sat_colour pass%0d px%0d: got %h expected %h", p, r, cap_col[c], prev_exp[r]);
               end
            end
         end
      end
   endtask

   task automatic test_bypass;
      send_line(448, 2, 1'b1, 1'b0, 1'b0, 1'b1);
      for (int c = 0; c < 4 * cap_len; c++) begin
         vectors++;
         if (cap_col[c] !== cap_in[c]) begin
            miscompares++;
            $display("FAIL bypass_colour cyc%0d: got %h expected %h", c, cap_col[c], cap_in[c]);
         end
         vectors++;
         if (cap_hs[c] !== cap_hin[c] || cap_vs[c] !== cap_vin[c]) begin
            miscompares++;
            $display("FAIL bypass_sync cyc%0d: got h%b v%b expected h%b v%b", c, cap_hs[c], cap_vs[c], cap_hin[c], cap_vin[c]);
         end
      end
      send_line(448, 0, 1'b1, 1'b0, 1'b1, 1'b0);
      for (int r = 0; r < prev_len; r++) begin
         for (int p = 0; p < 2; p++) begin
            int c;
            c = (p == 0) ? 2 * r - 2 : 2 * prev_len + 2 * r - 2;
            if (c >= 0 && c <= 4 * cap_len - 2) begin
               vectors++;
               if (cap_col[c] !== prev_exp[r]) begin
                  miscompares++;
                  $display("FAIL resume_colour pass%0d px%0d: got %h expected %h", p, r, cap_col[c], prev_exp[r]);
               end
            end
         end
      end
   endtask

   task automatic test_scanlines;
      scanlines = 1'b1;
      send_line(448, 1, 1'b1, 1'b0, 1'b1, 1'b0);
      send_line(448, 0, 1'b1, 1'b0, 1'b1, 1'b0);
      for (int r = 0; r < 448; r++) begin
         for (int p = 0; p < 2; p++) begin
            int c;
            logic [8:0] e;
            c = (p == 0) ? 2 * r - 2 : 2 * 448 + 2 * r - 2;
            e = (p == 1) ? SL_EXP : 9'h1FF;
            if (c >= 0) begin
               vectors++;
               if (cap_col[c] !== e) begin
                  miscompares++;
                  $display("FAIL scanline_colour pass%0d px%0d: got %h expected %h", p, r, cap_col[c], e);
               end
            end
         end
      end
      scanlines = 1'b0;
   endtask

   task automatic test_vsync;
      send_line(448, 0, 1'b1, 1'b0, 1'b1, 1'b1);
      for (int c = 96; c < 148; c++) begin
         logic e;
         e = (c >= 101 && c <= 140) ? 1'b0 : 1'b1;
         vectors++;
         if (cap_vs[c] !== e) begin
            miscompares++;
            $display("FAIL vsync_delay cyc%0d: got %b expected %b", c, cap_vs[c], e);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 512; i++) cur_exp[i] = 9'h000;
      test_reset;
      test_ramp;
      test_glitch;
      test_long_line;
      test_bypass;
      test_scanlines;
      test_vsync;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2ms;
      miscompares++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
